// File: rtl/memoria_de_instrucciones_if.sv
`default_nettype none
// ============================================================================
//  Module      : memoria_de_instrucciones_if
//  Description : Fetch/load bus between the program counter, the program
//                loader and the instruction memory. o_error_paridad exists
//                only when MEM_PARIDAD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface memoria_de_instrucciones_if #(
    parameter int DATA_W = 32
);
    logic [6:0]        i_direccion;
    logic              read_e;
    logic              carga_inicio;
    logic              carga_e;
    logic [DATA_W-1:0] carga_dato;
    logic [6:0]        cantidad_instrucciones;
    logic [DATA_W-1:0] o_instruccion;
    logic              o_instruccion_valida;
    logic              o_fin;
    logic              o_error;
`ifdef MEM_PARIDAD_EN
    logic              o_error_paridad;
`endif

    // master = program counter / loader side, slave = the memory
    modport master (
        output i_direccion, read_e, carga_inicio, carga_e, carga_dato,
`ifdef MEM_PARIDAD_EN
        input  o_error_paridad,
`endif
        input  cantidad_instrucciones, o_instruccion, o_instruccion_valida,
               o_fin, o_error
    );

    modport slave (
        input  i_direccion, read_e, carga_inicio, carga_e, carga_dato,
`ifdef MEM_PARIDAD_EN
        output o_error_paridad,
`endif
        output cantidad_instrucciones, o_instruccion, o_instruccion_valida,
               o_fin, o_error
    );
endinterface
`default_nettype wire

// File: rtl/memoria_de_instrucciones.sv
`default_nettype none
// ============================================================================
//  Module      : memoria_de_instrucciones
//  Description : Loadable instruction memory answering program-counter
//                fetches with a one-cycle valid strobe and end-of-program
//                pulse. Optional even-parity protection via MEM_PARIDAD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module memoria_de_instrucciones #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128   // at most 128: the fetch address is 7 bits
) (
    input  logic                        clk,
    input  logic                        reset,
    memoria_de_instrucciones_if.slave   bus
);

    localparam logic [7:0] c_depth = 8'(DEPTH);

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        LECTURA  = 2'd1,
        ESPERA   = 2'd2,
        FIN      = 2'd3
    } estado_t;

    estado_t           state_q, state_d;
    logic [6:0]        dir_q, dir_d;
    logic [7:0]        count_q, count_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valida_q, valida_d;
    logic              fin_q, fin_d;
    logic              error_q, error_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              w_wr_en;
    logic [6:0]        w_wr_addr;
    logic              w_en_rango;
    logic [DATA_W-1:0] w_palabra;

`ifdef MEM_PARIDAD_EN
    logic              mem_par [DEPTH];
    logic              par_q, par_d;
    logic              w_par_mal;
`endif

    // Count doubles as the load pointer: both advance and clear together.
    assign w_en_rango = ({1'b0, dir_q} < count_q);
    assign w_palabra  = mem[dir_q];

`ifdef MEM_PARIDAD_EN
    assign w_par_mal  = (^w_palabra) != mem_par[dir_q];
`endif

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        count_d   = count_q;
        instr_d   = instr_q;
        valida_d  = 1'b0;
        fin_d     = (state_q == FIN);
        error_d   = error_q;
        w_wr_en   = 1'b0;
        w_wr_addr = count_q[6:0];
`ifdef MEM_PARIDAD_EN
        par_d     = 1'b0;
`endif

        if (bus.carga_inicio) begin
            error_d = 1'b0;
        end

        case (state_q)
            INACTIVO: begin
                if (bus.carga_inicio) begin
                    count_d   = 8'd0;
                    w_wr_addr = 7'd0;
                    if (bus.carga_e) begin
                        w_wr_en = 1'b1;
                        count_d = 8'd1;
                    end
                end else if (bus.carga_e && (count_q < c_depth)) begin
                    w_wr_en = 1'b1;
                    count_d = count_q + 8'd1;
                end

                if (bus.read_e && (count_q != 8'd0)) begin
                    dir_d   = 7'd0;
                    state_d = LECTURA;
                end
            end

            LECTURA: begin
                valida_d = 1'b1;
                if (w_en_rango) begin
                    instr_d = w_palabra;
`ifdef MEM_PARIDAD_EN
                    par_d   = w_par_mal;
`endif
                end else begin
                    instr_d = '0;
                    error_d = 1'b1;
                end
                state_d = bus.read_e ? ESPERA : FIN;
            end

            ESPERA: begin
                // read_e falling takes priority over a simultaneous address change
                if (!bus.read_e) begin
                    state_d = FIN;
                end else if (bus.i_direccion != dir_q) begin
                    dir_d   = bus.i_direccion;
                    state_d = LECTURA;
                end
            end

            FIN: begin
                state_d = INACTIVO;
            end

            default: begin
                state_d = INACTIVO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= INACTIVO;
            dir_q    <= 7'd0;
            instr_q  <= '0;
            valida_q <= 1'b0;
            fin_q    <= 1'b0;
            error_q  <= 1'b0;
`ifdef MEM_PARIDAD_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            instr_q  <= instr_d;
            valida_q <= valida_d;
            fin_q    <= fin_d;
            error_q  <= error_d;
`ifdef MEM_PARIDAD_EN
            par_q    <= par_d;
`endif
        end
    end

    // The program and its size survive reset; only carga_inicio clears the count.
    always_ff @(posedge clk) begin
        count_q <= count_d;
        if (w_wr_en) begin
            mem[w_wr_addr] <= bus.carga_dato;
`ifdef MEM_PARIDAD_EN
            mem_par[w_wr_addr] <= ^bus.carga_dato;
`endif
        end
    end

    assign bus.cantidad_instrucciones = (count_q == 8'd0) ? 7'd0 : 7'(count_q - 8'd1);
    assign bus.o_instruccion          = instr_q;
    assign bus.o_instruccion_valida   = valida_q;
    assign bus.o_fin                  = fin_q;
    assign bus.o_error                = error_q;
`ifdef MEM_PARIDAD_EN
    assign bus.o_error_paridad        = par_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memoria_de_instrucciones.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memoria_de_instrucciones
//  Description : Self-checking bench for memoria_de_instrucciones.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memoria_de_instrucciones;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memoria_de_instrucciones_if #(.DATA_W(32)) bus();

    memoria_de_instrucciones #(.DATA_W(32), .DEPTH(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mmem [128];
    int          mcount = 0;
    logic        merr   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_restart();
        bus.carga_inicio = 1'b1;
        tick();
        bus.carga_inicio = 1'b0;
        mcount = 0;
        merr   = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        bus.carga_e    = 1'b1;
        bus.carga_dato = w;
        tick();
        bus.carga_e    = 1'b0;
        if (mcount < 128) begin
            mmem[mcount] = w;
            mcount++;
        end
    endtask

    // From INACTIVO: first fetch is always address 0, valid two edges later.
    task automatic start_read(input logic [31:0] exp0, input string tag);
        bus.read_e      = 1'b1;
        bus.i_direccion = 7'd0;
        tick();
        check({tag, "_v_before"}, 32'(bus.o_instruccion_valida), 32'd0);
        tick();
        check({tag, "_v0"}, 32'(bus.o_instruccion_valida), 32'd1);
        check({tag, "_d0"}, bus.o_instruccion, exp0);
    endtask

    // From ESPERA with a different address: exactly one pulse within 3 cycles.
    task automatic fetch(input logic [6:0] a, input logic [31:0] exp_d,
                         input logic exp_e, input string tag);
        bus.i_direccion = a;
        tick();
        check({tag, "_v_pre"}, 32'(bus.o_instruccion_valida), 32'd0);
        tick();
        check({tag, "_v"}, 32'(bus.o_instruccion_valida), 32'd1);
        check({tag, "_d"}, bus.o_instruccion, exp_d);
        check({tag, "_err"}, 32'(bus.o_error), 32'(exp_e));
`ifdef MEM_PARIDAD_EN
        check({tag, "_par"}, 32'(bus.o_error_paridad), 32'd0);
`endif
        tick();
        check({tag, "_v_post"}, 32'(bus.o_instruccion_valida), 32'd0);
    endtask

    task automatic finish_read();
        bus.read_e = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        vec_t vecs[2];
        vecs[0] = '{addr: 7'd1, data: 32'hA1, err: 1'b0};
        vecs[1] = '{addr: 7'd2, data: 32'hA2, err: 1'b0};

        reset            = 1'b1;
        bus.i_direccion  = 7'd0;
        bus.read_e       = 1'b0;
        bus.carga_inicio = 1'b0;
        bus.carga_e      = 1'b0;
        bus.carga_dato   = 32'd0;
        tick();
        check("rst_instr", bus.o_instruccion, 32'd0);
        check("rst_valid", 32'(bus.o_instruccion_valida), 32'd0);
        check("rst_fin",   32'(bus.o_fin), 32'd0);
        check("rst_err",   32'(bus.o_error), 32'd0);
        reset = 1'b0;
        tick();

        // Load 0xA0..0xA3
        load_restart();
        for (int i = 0; i < 4; i++) load_word(32'hA0 + 32'(i));
        check("cant_4", 32'(bus.cantidad_instrucciones), 32'd3);

        start_read(32'hA0, "first");
        for (int i = 0; i < 2; i++)
            fetch(vecs[i].addr, vecs[i].data, vecs[i].err, $sformatf("tbl%0d", i));

        // read_e drops while LECTURA is in progress
        bus.i_direccion = 7'd3;
        tick();
        bus.read_e = 1'b0;
        tick();
        check("drop_v",   32'(bus.o_instruccion_valida), 32'd1);
        check("drop_d",   bus.o_instruccion, 32'hA3);
        check("drop_fin0", 32'(bus.o_fin), 32'd0);
        tick();
        check("drop_fin1", 32'(bus.o_fin), 32'd1);
        check("drop_v1",  32'(bus.o_instruccion_valida), 32'd0);
        tick();
        check("drop_fin2", 32'(bus.o_fin), 32'd0);

        // read_e falls together with an address change: FIN wins
        start_read(32'hA0, "finwin");
        bus.read_e      = 1'b0;
        bus.i_direccion = 7'd2;
        tick();
        check("finwin_v", 32'(bus.o_instruccion_valida), 32'd0);
        tick();
        check("finwin_fin", 32'(bus.o_fin), 32'd1);
        check("finwin_v2", 32'(bus.o_instruccion_valida), 32'd0);
        tick();

        // Reset between the address change and the valid pulse
        start_read(32'hA0, "rstmid");
        bus.i_direccion = 7'd1;
        tick();
        #2 reset = 1'b1;
        #1;
        check("rstmid_instr", bus.o_instruccion, 32'd0);
        check("rstmid_v",     32'(bus.o_instruccion_valida), 32'd0);
        check("rstmid_fin",   32'(bus.o_fin), 32'd0);
        @(posedge clk);
        #1;
        check("rstmid_nopulse", 32'(bus.o_instruccion_valida), 32'd0);
        reset = 1'b0;
        check("rstmid_cant", 32'(bus.cantidad_instrucciones), 32'd3);
        tick();
        check("rstmid_restart_pre", 32'(bus.o_instruccion_valida), 32'd0);
        tick();
        check("rstmid_restart_v", 32'(bus.o_instruccion_valida), 32'd1);
        check("rstmid_restart_d", bus.o_instruccion, 32'hA0);
        fetch(7'd1, 32'hA1, 1'b0, "rstmid_a1");
        finish_read();

        // Out-of-range fetch: sticky error until carga_inicio
        start_read(32'hA0, "oor");
        fetch(7'd5, 32'd0, 1'b1, "oor5");
        tick();
        check("oor_sticky", 32'(bus.o_error), 32'd1);
        finish_read();
        check("oor_idle", 32'(bus.o_error), 32'd1);
        load_restart();
        check("oor_clr", 32'(bus.o_error), 32'd0);
        check("cant_0", 32'(bus.cantidad_instrucciones), 32'd0);

        // read_e with an empty program stays idle
        bus.read_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("empty_v%0d", i), 32'(bus.o_instruccion_valida), 32'd0);
        end
        bus.read_e = 1'b0;
        tick();

        // 129 words, first one written with carga_inicio in the same cycle
        bus.carga_inicio = 1'b1;
        bus.carga_e      = 1'b1;
        bus.carga_dato   = 32'h1000_0000;
        tick();
        bus.carga_inicio = 1'b0;
        bus.carga_e      = 1'b0;
        mmem[0] = 32'h1000_0000;
        mcount  = 1;
        merr    = 1'b0;
        check("cant_1", 32'(bus.cantidad_instrucciones), 32'd0);
        for (int i = 1; i < 129; i++) load_word(32'h1000_0000 + 32'(i));
        check("cant_full", 32'(bus.cantidad_instrucciones), 32'd127);
        start_read(32'h1000_0000, "full0");
        fetch(7'd127, 32'h1000_007F, 1'b0, "full127");
        fetch(7'd0, 32'h1000_0000, 1'b0, "fullwrap");
        finish_read();

        // Randomized programs and fetch sequences against the model
        for (int r = 0; r < 4; r++) begin
            int n;
            logic [6:0] cur;
            load_restart();
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) load_word($urandom);
            check($sformatf("rnd%0d_cant", r), 32'(bus.cantidad_instrucciones), 32'(mcount - 1));
            start_read(mmem[0], $sformatf("rnd%0d_start", r));
            cur = 7'd0;
            for (int s = 0; s < 10; s++) begin
                logic [6:0] a;
                a = 7'($urandom_range(0, 31));
                if (a == cur) begin
                    bus.i_direccion = a;
                    for (int c = 0; c < 3; c++) begin
                        tick();
                        check($sformatf("rnd%0d_hold%0d", r, s), 32'(bus.o_instruccion_valida), 32'd0);
                    end
                end else begin
                    if (int'(a) >= mcount) merr = 1'b1;
                    fetch(a, (int'(a) < mcount) ? mmem[a] : 32'd0, merr,
                          $sformatf("rnd%0d_s%0d", r, s));
                    cur = a;
                end
            end
            finish_read();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
